iob_ram_dp_be_ctrl: RTL and testbench

- IOb native-bus responder that drives the port pins of the dual-port byte-enable SRAM wrapper (port A write, port B read).
- The hard macro's write mask is tied full-word, so this block emulates byte enables by read-modify-write.
- Sits between the SoC interconnect and the internal SRAM: bus on one side, SRAM pins on the other.

---
 rtl/iob_ram_dp_be_ctrl_pkg.sv | 14 +
 rtl/iob_ram_dp_be_ctrl_if.sv | 17 +
 rtl/iob_ram_dp_be_ctrl_merge.sv | 20 ++
 rtl/iob_ram_dp_be_ctrl.sv | 127 ++++++++++++
 tb/tb_iob_ram_dp_be_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/iob_ram_dp_be_ctrl_pkg.sv
// Shared definitions for the byte-enable SRAM controller: FSM state
// encoding and the default word geometry.
package iob_ram_ctrl_pkg;

  // Default word geometry; modules derive their own from DATA_W
  localparam int PKG_DATA_W = 32;
  localparam int NBYTES = PKG_DATA_W / 8;
  localparam logic [NBYTES-1:0] STRB_FULL = {NBYTES{1'b1}};

  // Controller states, kept as plain constants so older tools can read them
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

endpackage

// File: rtl/iob_ram_dp_be_ctrl_if.sv
// IOb native bus seen by the SRAM controller. The SoC interconnect is the
// master; the controller is the slave.
interface iob_ram_dp_be_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                ready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata, rvalid);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata, rvalid);
endinterface

// File: rtl/iob_ram_dp_be_ctrl_merge.sv
// Per-byte select between an old and a new word; a set strobe bit takes
// the new byte, a clear one keeps the old byte.
module iob_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   new_i,
  input  logic [DATA_W/8-1:0] strb_i,
  output logic [DATA_W-1:0]   merged_o
);

  // Start from the old word and overwrite each strobed byte
  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (strb_i[i]) merged_o[i*8 +: 8] = new_i[i*8 +: 8];
    end
  end

endmodule

// File: rtl/iob_ram_dp_be_ctrl.sv
// IOb responder driving a dual-port SRAM (A = write, B = read) whose write
// mask is tied full-word. Partial writes become a read of the old word in
// the accept cycle followed by a full-word write of the merged word.
module iob_ram_dp_be_ctrl
  import iob_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  iob_ram_dp_be_ctrl_if.slave bus,
  output logic                enA,
  output logic [DATA_W/8-1:0] weA,
  output logic [ADDR_W-1:0]   addrA,
  output logic [DATA_W-1:0]   dinA,
  output logic                enB,
  output logic [ADDR_W-1:0]   addrB,
  input  logic [DATA_W-1:0]   doutB
);

  localparam int NB = DATA_W / 8;
  localparam logic [NB-1:0] FULL = '1;

  logic [0:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     strb_q, strb_d;

  logic              accept;
  logic              isRead;
  logic              isFull;
  logic              isPartial;
  logic [DATA_W-1:0] merged;

  // Classify the request being accepted this cycle, if any
  always_comb begin
    accept    = bus.valid & ready_q;
    isRead    = accept & (bus.wstrb == '0);
    isFull    = accept & (bus.wstrb == FULL);
    isPartial = accept & (bus.wstrb != '0) & (bus.wstrb != FULL);
  end

  iob_byte_merge #(
    .DATA_W(DATA_W)
  ) u_merge (
    .old_i   (doutB),
    .new_i   (wdata_q),
    .strb_i  (strb_q),
    .merged_o(merged)
  );

  // Next state: a partial write parks its fields and spends one cycle merging
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    rvalid_d = isRead;
    case (state_q)
      IDLE: begin
        if (isPartial) begin
          state_d = MERGE;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          strb_d  = bus.wstrb;
        end
      end
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and handshake registers; ready rises the cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
    end
  end

  // SRAM pins: merge write-back in MERGE, direct accesses in the accept cycle
  always_comb begin
    enA   = 1'b0;
    weA   = '0;
    addrA = '0;
    dinA  = '0;
    enB   = 1'b0;
    addrB = '0;
    if (state_q == MERGE) begin
      enA   = 1'b1;
      weA   = FULL;
      addrA = addr_q;
      dinA  = merged;
    end else begin
      if (isFull) begin
        enA   = 1'b1;
        weA   = FULL;
        addrA = bus.addr;
        dinA  = bus.wdata;
      end
      if (isRead | isPartial) begin
        enB   = 1'b1;
        addrB = bus.addr;
      end
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rvalid_q ? doutB : '0;

endmodule

// File: tb/tb_iob_ram_dp_be_ctrl.sv
// Bench for iob_ram_dp_be_ctrl: a directed cycle table, reset sequences,
// and random traffic checked against a word-array model of memory.
module tb_iob_ram_dp_be_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iob_ram_dp_be_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic              enA, enB;
  logic [3:0]        weA;
  logic [ADDR_W-1:0] addrA, addrB;
  logic [DATA_W-1:0] dinA, doutB;

  iob_ram_dp_be_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .enA  (enA),
    .weA  (weA),
    .addrA(addrA),
    .dinA (dinA),
    .enB  (enB),
    .addrB(addrB),
    .doutB(doutB)
  );

  // SRAM macro model: full-word write on A, registered read on B, cleared once
  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  logic memCleared = 1'b0;
  always @(posedge clk) begin
    if (!memCleared) begin
      for (int i = 0; i < (1 << ADDR_W); i++) sram[i] <= '0;
      memCleared <= 1'b1;
      doutB <= '0;
    end else begin
      if (enA && weA == 4'hF) sram[addrA] <= dinA;
      if (enB) doutB <= sram[addrB];
    end
  end

  int checkCount = 0;
  int passCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                               input logic [31:0] wd, input logic [3:0] ws);
    bus.valid = v;
    bus.addr  = a;
    bus.wdata = wd;
    bus.wstrb = ws;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              expReady;
    logic              expRvalid;
    logic [31:0]       expRdata;
    logic              expEnA;
    logic              expEnB;
  } vec_t;

  vec_t vecs [20];

  // Word-level reference memory for the random phase
  logic [31:0] refMem [0:(1<<ADDR_W)-1];

  initial begin
    logic        stallNext, rdPending, newRd, newStall, v, expReady, expEnA, expEnB;
    logic [31:0] rdExp, wd, word;
    logic [9:0]  a;
    logic [3:0]  ws;

    // cycle table: inputs of the cycle, outputs seen mid-cycle
    vecs[0]  = '{1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[1]  = '{1'b1, 10'd5, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[2]  = '{1'b0, 10'd0, 32'h0,        4'h0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 10'd5, 32'h11223344, 4'h5, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[4]  = '{1'b1, 10'd5, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[5]  = '{1'b1, 10'd5, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[6]  = '{1'b0, 10'd0, 32'h0,        4'h0, 1'b1, 1'b1, 32'hDE22BE44, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 10'd0, 32'h000000A0, 4'hF, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[8]  = '{1'b1, 10'd1, 32'h000000A1, 4'hF, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[9]  = '{1'b1, 10'd2, 32'h000000A2, 4'hF, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[10] = '{1'b1, 10'd3, 32'h000000A3, 4'hF, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[11] = '{1'b1, 10'd0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[12] = '{1'b1, 10'd1, 32'h0,        4'h0, 1'b1, 1'b1, 32'h000000A0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 10'd2, 32'h0,        4'h0, 1'b1, 1'b1, 32'h000000A1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 10'd3, 32'h0,        4'h0, 1'b1, 1'b1, 32'h000000A2, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 10'd0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h000000A3, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 10'd5, 32'hFF000000, 4'h8, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[17] = '{1'b1, 10'd5, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[18] = '{1'b1, 10'd5, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[19] = '{1'b0, 10'd0, 32'h0,        4'h0, 1'b1, 1'b1, 32'hFF22BE44, 1'b0, 1'b0};

    for (int i = 0; i < (1 << ADDR_W); i++) refMem[i] = '0;

    // reset held with a read request pending: everything must stay quiet
    applyStimulus(1'b1, 10'd9, 32'h0, 4'h0);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("rst_ready", {31'b0, bus.ready}, 32'h0);
    checkOutput("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_enA", {31'b0, enA}, 32'h0);
    checkOutput("rst_weA", {28'b0, weA}, 32'h0);
    checkOutput("rst_enB", {31'b0, enB}, 32'h0);
    checkOutput("rst_pins", {addrA, addrB, 12'b0} | dinA, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 10'd0, 32'h0, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_ready_same", {31'b0, bus.ready}, 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rel_ready_next", {31'b0, bus.ready}, 32'h1);
    nextCycle();

    // directed cycle table
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready", i), {31'b0, bus.ready}, {31'b0, vecs[i].expReady});
      checkOutput($sformatf("vec%0d_rvalid", i), {31'b0, bus.rvalid}, {31'b0, vecs[i].expRvalid});
      checkOutput($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d_enA", i), {31'b0, enA}, {31'b0, vecs[i].expEnA});
      checkOutput($sformatf("vec%0d_weA", i), {28'b0, weA}, vecs[i].expEnA ? 32'hF : 32'h0);
      checkOutput($sformatf("vec%0d_enB", i), {31'b0, enB}, {31'b0, vecs[i].expEnB});
      nextCycle();
    end

    // reset asserted in the merge cycle of a partial write to word 7
    applyStimulus(1'b1, 10'd7, 32'h000000FF, 4'h1);
    @(negedge clk);
    checkOutput("rmw7_ready", {31'b0, bus.ready}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 10'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rmw7_merge_enA", {31'b0, enA}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rmw7_rst_enA", {31'b0, enA}, 32'h0);
    checkOutput("rmw7_rst_ready", {31'b0, bus.ready}, 32'h0);
    checkOutput("rmw7_rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 10'd7, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd7_ready", {31'b0, bus.ready}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 10'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd7_rvalid", {31'b0, bus.rvalid}, 32'h1);
    checkOutput("rd7_rdata", bus.rdata, 32'h0);
    nextCycle();

    // random traffic on words 32..39 against the reference memory
    stallNext = 1'b0;
    rdPending = 1'b0;
    rdExp = '0;
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      a  = 10'(32 + $urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 2))
        0:       ws = 4'h0;
        1:       ws = 4'hF;
        default: ws = 4'($urandom_range(1, 14));
      endcase
      applyStimulus(v, a, wd, ws);
      expReady = !stallNext;
      expEnA = stallNext || (v && expReady && ws == 4'hF);
      expEnB = v && expReady && ws != 4'hF;
      @(negedge clk);
      checkOutput("rnd_ready", {31'b0, bus.ready}, {31'b0, expReady});
      checkOutput("rnd_rvalid", {31'b0, bus.rvalid}, {31'b0, rdPending});
      checkOutput("rnd_rdata", bus.rdata, rdPending ? rdExp : 32'h0);
      checkOutput("rnd_enA", {31'b0, enA}, {31'b0, expEnA});
      checkOutput("rnd_enB", {31'b0, enB}, {31'b0, expEnB});
      newRd = 1'b0;
      newStall = 1'b0;
      if (v && expReady) begin
        if (ws == 4'h0) begin
          newRd = 1'b1;
          rdExp = refMem[a];
        end else begin
          word = refMem[a];
          for (int b = 0; b < 4; b++) if (ws[b]) word[b*8 +: 8] = wd[b*8 +: 8];
          refMem[a] = word;
          newStall = (ws != 4'hF);
        end
      end
      rdPending = newRd;
      stallNext = newStall;
      nextCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
